fp_addsub_sequencer: RTL and testbench
======================================

Name: fp_addsub_sequencer

Overview:
- Upstream command/issue stage for the 32-bit floating-point adder/subtractor.
- Accepts add/sub requests on a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Issues them one at a time over the adder's start/busy/done handshake, with a watchdog.
- Returns each result, with its tag and IEEE-754 class flags, on a valid/ready result interface in request order.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the user tag carried request-to-result.
- TIMEOUT, 64, max cycles from start pulse to adder completion before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept; equals !fifo_full.
- req_op  in  1  0 = add, 1 = subtract.
- req_a  in  32  operand A, IEEE-754 single.
- req_b  in  32  operand B, IEEE-754 single.
- req_tag  in  TAG_W  user tag.
- alu_start  out  1  one-cycle start pulse to adder.
- alu_subtract  out  1  op to adder; held for whole operation.
- alu_a  out  32  operand A to adder; held for whole operation.
- alu_b  out  32  operand B to adder; held for whole operation.
- alu_rst  out  1  active-high adder reset = !rst OR watchdog abort pulse.
- alu_busy  in  1  adder busy.
- alu_done  in  1  adder done (level; stale-high until next start).
- alu_z  in  32  adder result.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts.
- res_z  out  32  result word.
- res_tag  out  TAG_W  tag of the originating request.
- res_flags  out  5  {timeout, nan, inf, zero, denorm}.

Behaviour:
Reset:
- While rst = 0, asynchronously: FIFO empty (pointers and count = 0), FSM = IDLE, watchdog = 0.
- All registered outputs = 0; req_ready = 1 once rst releases.
- alu_rst = 1 while rst = 0.
- Reset mid-operation discards the in-flight op and all queued requests; no result is produced for them.

FIFO:
- Push when req_valid && req_ready.
- Pop only in IDLE when not empty.
- Push and pop in the same cycle is legal when not full; count is unchanged.
- No push when full (req_ready = 0).
- Pointers are log2(DEPTH) bits and wrap naturally.
- Entry = {op, a, b, tag}.

FSM states:
- IDLE:
  - If FIFO non-empty: latch head into operand/op/tag registers (driving alu_*), pop, go ISSUE.
  - Total buffering capacity is DEPTH + 1 requests (FIFO plus operand registers).
- ISSUE:
  - alu_start = 1 for exactly this cycle; clear watchdog; go WAIT_ACK.
- WAIT_ACK:
  - Ignore alu_done (may be stale from the previous op).
  - alu_busy = 1 -> WAIT_DONE.
- WAIT_DONE:
  - alu_done && !alu_busy -> capture alu_z into res_z, compute flags, go OUTPUT.
- OUTPUT:
  - res_valid = 1; res_z/res_tag/res_flags stable.
  - res_ready = 1 -> res_valid = 0 next cycle, go IDLE.
  - res_valid is never dropped without acceptance.

Watchdog:
- Increments each cycle in WAIT_ACK/WAIT_DONE.
- When it reaches TIMEOUT-1 without completion:
  - res_z = 32'h7FC00000, res_flags = 5'b10000.
  - alu_rst pulses high for 1 cycle.
  - FSM goes OUTPUT.
- Completion and timeout in the same cycle: completion wins.

Operand holding:
- alu_a/alu_b/alu_subtract change only on the IDLE pop.
- They stay stable from ISSUE through OUTPUT, because the adder samples operands the cycle after start.

Latency:
- Request accepted at edge N into an empty FIFO with FSM in IDLE: alu_start high during cycle N+2.
- With adder latency L cycles (start to done), res_valid rises L+3 cycles after alu_start (+1 ack, +1 capture, +1 register).

Flags (from res_z, exponent e = [30:23], mantissa m = [22:0]):
- nan = (e == FF && m != 0)
- inf = (e == FF && m == 0)
- zero = (e == 0 && m == 0)
- denorm = (e == 0 && m != 0)
- At most one of these is set.

Ordering: results are returned strictly in request order; tags are passed through unmodified.

Test Plan:
- Single add: a = 3F800000, b = 40000000, op = 0, tag = 5 -> one res_valid with res_z = 40400000, tag = 5, flags = 00000; alu_start high exactly 1 cycle.
- Subtract to zero: a = b = 40400000, op = 1 -> res_z = 00000000, flags = 00010.
- Backpressure/full: res_ready held 0, push 7 requests with tags 0..6 -> req_ready drops after 5 accepted (tags 0..4), and tag 0 result is held stable. Then release res_ready -> results delivered with tags 0,1,2,3,4 in order; remaining pushes accepted as space frees.
- Special: a = 7F800000, b = FF800000, op = 0 -> NaN result, flags = 01000 (nan).
- Watchdog: adder model never asserts alu_busy -> 64 cycles after alu_start: alu_rst 1-cycle pulse, res_z = 7FC00000, flags = 10000; next queued request then issues normally.
- Reset mid-op: drop rst in WAIT_DONE with 2 requests queued -> all outputs 0 immediately, alu_rst = 1, no result emitted; after release, a new request completes normally.

Source files
------------

// File: rtl/fp_addsub_sequencer.sv
// Command/issue stage for the single-precision adder: queues add/sub requests,
// drives the adder handshake under a watchdog, and returns tagged, classified results in order.
module fp_addsub_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_op_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             alu_start_o,
  output logic             alu_subtract_o,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  output logic             alu_rst_o,
  input  logic             alu_busy_i,
  input  logic             alu_done_i,
  input  logic [31:0]      alu_z_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_z_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic [4:0]       res_flags_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 1 + 32 + 32 + TAG_W;
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  localparam logic [31:0] TIMEOUT_Z = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    OUTPUT
  } state_e;

  state_e state_q, state_d;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;

  logic               fifo_full, fifo_empty, push, pop;
  logic [ENTRY_W-1:0] wr_entry, head_entry;
  logic               head_op;
  logic [31:0]        head_a, head_b;
  logic [TAG_W-1:0]   head_tag;

  logic               op_q;
  logic [31:0]        a_q, b_q;
  logic [TAG_W-1:0]   tag_q;
  logic [WD_W-1:0]    wdog_q;

  logic               res_valid_q;
  logic [31:0]        res_z_q;
  logic [TAG_W-1:0]   res_tag_q;
  logic [4:0]         res_flags_q;

  logic               wd_expired, complete, timeout_fire;
  logic [3:0]         z_class;

  assign fifo_full   = (count_q == (PTR_W+1)'(DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign req_ready_o = rst_ni && !fifo_full;
  assign push        = req_valid_i && req_ready_o;
  assign pop         = (state_q == IDLE) && !fifo_empty;

  assign wr_entry   = {req_op_i, req_a_i, req_b_i, req_tag_i};
  assign head_entry = mem_q[rd_ptr_q];
  assign {head_op, head_a, head_b, head_tag} = head_entry;

  // Storage has no reset: an entry is only ever read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign wd_expired = (wdog_q == WD_W'(TIMEOUT - 1));

  // WAIT_ACK never looks at alu_done, which may still be high from the previous operation.
  always_comb begin
    state_d      = state_q;
    complete     = 1'b0;
    timeout_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (wd_expired) begin
          timeout_fire = 1'b1;
          state_d      = OUTPUT;
        end else if (alu_busy_i) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (alu_done_i && !alu_busy_i) begin
          complete = 1'b1;
          state_d  = OUTPUT;
        end else if (wd_expired) begin
          timeout_fire = 1'b1;
          state_d      = OUTPUT;
        end
      end
      OUTPUT: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Class bits in result-flag order: {nan, inf, zero, denorm}.
  always_comb begin
    z_class = 4'b0000;
    if (alu_z_i[30:23] == 8'hFF) begin
      z_class = (alu_z_i[22:0] != '0) ? 4'b1000 : 4'b0100;
    end else if (alu_z_i[30:23] == 8'h00) begin
      z_class = (alu_z_i[22:0] == '0) ? 4'b0010 : 4'b0001;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      wdog_q <= '0;
    end else begin
      if (pop) begin
        op_q  <= head_op;
        a_q   <= head_a;
        b_q   <= head_b;
        tag_q <= head_tag;
      end
      if (state_q == ISSUE) begin
        wdog_q <= '0;
      end else if ((state_q == WAIT_ACK) || (state_q == WAIT_DONE)) begin
        wdog_q <= wdog_q + 1'b1;
      end
    end
  end

  // The result registers only change on entry to OUTPUT, so they hold steady under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= 1'b0;
      res_z_q     <= '0;
      res_tag_q   <= '0;
      res_flags_q <= '0;
    end else begin
      if (complete) begin
        res_valid_q <= 1'b1;
        res_z_q     <= alu_z_i;
        res_tag_q   <= tag_q;
        res_flags_q <= {1'b0, z_class};
      end else if (timeout_fire) begin
        res_valid_q <= 1'b1;
        res_z_q     <= TIMEOUT_Z;
        res_tag_q   <= tag_q;
        res_flags_q <= 5'b10000;
      end else if ((state_q == OUTPUT) && res_ready_i) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign alu_start_o    = (state_q == ISSUE);
  assign alu_subtract_o = op_q;
  assign alu_a_o        = a_q;
  assign alu_b_o        = b_q;
  assign alu_rst_o      = !rst_ni || timeout_fire;

  assign res_valid_o = res_valid_q;
  assign res_z_o     = res_z_q;
  assign res_tag_o   = res_tag_q;
  assign res_flags_o = res_flags_q;

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Directed bench for fp_addsub_sequencer with a behavioural adder whose results come
// from a small table of hand-computed single-precision sums.
module tb_fp_addsub_sequencer;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             req_valid, req_op;
  logic [31:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic             req_ready_o;
  logic             alu_start_o, alu_subtract_o, alu_rst_o;
  logic [31:0]      alu_a_o, alu_b_o;
  logic             alu_busy, alu_done;
  logic [31:0]      alu_z;
  logic             res_ready;
  logic             res_valid_o;
  logic [31:0]      res_z_o;
  logic [TAG_W-1:0] res_tag_o;
  logic [4:0]       res_flags_o;

  int testsRun  = 0;
  int failCount = 0;

  int  modelLatency = 3;
  bit  modelHang    = 1'b0;
  logic        pending;
  int          cnt;
  logic        opS;
  logic [31:0] opA, opB;

  int  cyc = 0;
  int  startCount = 0;
  int  startWidthErr = 0;
  int  validCycles = 0;
  logic prevStart = 1'b0;

  fp_addsub_sequencer #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
    .alu_start_o(alu_start_o), .alu_subtract_o(alu_subtract_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_rst_o(alu_rst_o),
    .alu_busy_i(alu_busy), .alu_done_i(alu_done), .alu_z_i(alu_z),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready),
    .res_z_o(res_z_o), .res_tag_o(res_tag_o), .res_flags_o(res_flags_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fpModel(input logic s, input logic [31:0] a, input logic [31:0] b);
    case ({s, a, b})
      {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {1'b1, 32'h40400000, 32'h40400000}: return 32'h00000000;
      {1'b0, 32'h7F800000, 32'hFF800000}: return 32'h7FC00000;
      {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {1'b0, 32'h7F000000, 32'h7F000000}: return 32'h7F800000;
      {1'b1, 32'h00800000, 32'h00400000}: return 32'h00400000;
      default:                            return 32'hDEADBEEF;
    endcase
  endfunction

  // Adder model: raises busy one cycle after the start pulse, samples operands then,
  // and leaves done high until the next operation begins.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_rst_o) begin
      alu_busy <= 1'b0;
      alu_done <= 1'b0;
      alu_z    <= '0;
      pending  <= 1'b0;
      cnt      <= 0;
    end else if (alu_start_o) begin
      pending <= !modelHang;
    end else if (pending) begin
      pending  <= 1'b0;
      alu_busy <= 1'b1;
      alu_done <= 1'b0;
      opS      <= alu_subtract_o;
      opA      <= alu_a_o;
      opB      <= alu_b_o;
      cnt      <= modelLatency;
    end else if (alu_busy) begin
      if (cnt <= 1) begin
        alu_busy <= 1'b0;
        alu_done <= 1'b1;
        alu_z    <= fpModel(opS, opA, opB);
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (alu_start_o) begin
      startCount <= startCount + 1;
      if (prevStart) startWidthErr <= startWidthErr + 1;
    end
    prevStart <= alu_start_o;
    if (res_valid_o) validCycles <= validCycles + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [31:0] b,
                               input logic [TAG_W-1:0] tag);
    int   n = 0;
    logic acc = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    while (!acc && n < 300) begin
      acc = req_ready_o;
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    checkOutput($sformatf("accept tag %0d", tag), acc, 1'b1);
  endtask

  task automatic getResult(input string name, input logic [TAG_W-1:0] expTag,
                           input logic [31:0] expZ, input logic [4:0] expFlags);
    int n = 0;
    while (!res_valid_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " valid"}, res_valid_o, 1'b1);
    if (res_valid_o) begin
      checkOutput({name, " tag"}, res_tag_o, expTag);
      checkOutput({name, " z"}, res_z_o, expZ);
      checkOutput({name, " flags"}, res_flags_o, expFlags);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput({name, " dropped"}, res_valid_o, 1'b0);
    end
  endtask

  initial begin
    int n;
    int c0;
    int snapStart;
    int snapValid;

    rst_ni    = 1'b0;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    res_ready = 1'b0;
    #1;
    checkOutput("reset alu_rst", alu_rst_o, 1'b1);
    checkOutput("reset res_valid", res_valid_o, 1'b0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    checkOutput("post-reset req_ready", req_ready_o, 1'b1);
    checkOutput("post-reset alu_rst", alu_rst_o, 1'b0);

    // Single add, including operand holding while the result waits.
    snapStart = startCount;
    applyStimulus(1'b0, 32'h3F800000, 32'h40000000, 4'd5);
    n = 0;
    while (!res_valid_o && n < 300) begin @(negedge clk); n++; end
    checkOutput("add hold a", alu_a_o, 32'h3F800000);
    checkOutput("add hold b", alu_b_o, 32'h40000000);
    checkOutput("add hold op", alu_subtract_o, 1'b0);
    getResult("add", 4'd5, 32'h40400000, 5'b00000);
    checkOutput("add start count", startCount - snapStart, 1);
    checkOutput("start pulse width", startWidthErr, 0);

    applyStimulus(1'b1, 32'h40400000, 32'h40400000, 4'd6);
    getResult("sub zero", 4'd6, 32'h00000000, 5'b00010);
    applyStimulus(1'b0, 32'h7F800000, 32'hFF800000, 4'd7);
    getResult("inf-inf", 4'd7, 32'h7FC00000, 5'b01000);
    applyStimulus(1'b0, 32'h7F000000, 32'h7F000000, 4'd8);
    getResult("overflow", 4'd8, 32'h7F800000, 5'b00100);
    applyStimulus(1'b1, 32'h00800000, 32'h00400000, 4'd3);
    getResult("denorm", 4'd3, 32'h00400000, 5'b00001);

    // Backpressure: operand registers plus four FIFO entries absorb five requests.
    for (int t = 0; t < 5; t++) applyStimulus(1'b0, 32'h3F800000, 32'h3F800000, TAG_W'(t));
    checkOutput("full req_ready", req_ready_o, 1'b0);
    n = 0;
    while (!res_valid_o && n < 300) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    checkOutput("stall valid held", res_valid_o, 1'b1);
    checkOutput("stall tag held", res_tag_o, 4'd0);
    checkOutput("stall z held", res_z_o, 32'h40000000);
    checkOutput("stall still full", req_ready_o, 1'b0);
    fork
      begin
        applyStimulus(1'b0, 32'h3F800000, 32'h3F800000, 4'd5);
        applyStimulus(1'b0, 32'h3F800000, 32'h3F800000, 4'd6);
      end
      begin
        for (int t = 0; t < 7; t++)
          getResult($sformatf("order %0d", t), TAG_W'(t), 32'h40000000, 5'b00000);
      end
    join

    // Watchdog: the adder never acknowledges the first of two queued requests.
    modelHang = 1'b1;
    applyStimulus(1'b0, 32'h3F800000, 32'h40000000, 4'd9);
    applyStimulus(1'b0, 32'h3F800000, 32'h3F800000, 4'd10);
    n = 0;
    while (!alu_start_o && n < 50) begin @(negedge clk); n++; end
    c0 = cyc;
    n = 0;
    while (!alu_rst_o && n < 200) begin @(negedge clk); n++; end
    checkOutput("wdog alu_rst seen", alu_rst_o, 1'b1);
    checkOutput("wdog offset", 64'(cyc - c0), 64);
    modelHang = 1'b0;
    @(negedge clk);
    checkOutput("wdog pulse width", alu_rst_o, 1'b0);
    getResult("timeout", 4'd9, 32'h7FC00000, 5'b10000);
    getResult("after timeout", 4'd10, 32'h40000000, 5'b00000);

    // Reset in WAIT_DONE with two requests still queued.
    modelLatency = 20;
    applyStimulus(1'b0, 32'h3F800000, 32'h40000000, 4'd11);
    applyStimulus(1'b0, 32'h3F800000, 32'h3F800000, 4'd12);
    applyStimulus(1'b0, 32'h3F800000, 32'h3F800000, 4'd13);
    n = 0;
    while (!alu_busy && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    checkOutput("pre-reset busy", alu_busy, 1'b1);
    rst_ni = 1'b0;
    #1;
    checkOutput("mid reset outputs",
                {res_valid_o, alu_start_o, alu_subtract_o, alu_a_o, res_tag_o, res_flags_o},
                '0);
    checkOutput("mid reset z/b", {res_z_o, alu_b_o}, '0);
    checkOutput("mid reset alu_rst", alu_rst_o, 1'b1);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    modelLatency = 3;
    @(negedge clk);
    checkOutput("release req_ready", req_ready_o, 1'b1);
    snapStart = startCount;
    snapValid = validCycles;
    repeat (40) @(negedge clk);
    checkOutput("no stale result", validCycles - snapValid, 0);
    checkOutput("no stale issue", startCount - snapStart, 0);
    applyStimulus(1'b0, 32'h3F800000, 32'h40000000, 4'd14);
    getResult("after reset", 4'd14, 32'h40400000, 5'b00000);
    checkOutput("final start width", startWidthErr, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
